lfsr_noise_channel: RTL

Parametrised pseudorandom noise voice for the SSG sound path: an LFSR-based generator with a programmable step-rate divider, long/short period mode, runtime seed load and a volume-scaled output. It sits alongside the tone channels and feeds the mixer one `OUT_W`-bit unsigned sample per clock. With `Period=0`, long mode, `Volume=63` and no seed load, the output is bit-exact with the current fixed 16-bit noise generator.

---
 rtl/ssg_pkg.sv | 7 +
 rtl/ssg_rate_divider.sv | 35 +++
 rtl/lfsr_noise_channel.sv | 86 ++++++++
 3 files changed

// File: rtl/ssg_pkg.sv
// rtl/ssg_pkg.sv - shared constants for the SSG sound path
package ssg_pkg;
  localparam logic [15:0] SSG_NOISE_SEED  = 16'hF00F;
  localparam logic        SSG_NOISE_LONG  = 1'b0;
  localparam logic        SSG_NOISE_SHORT = 1'b1;
  localparam int          SSG_SAMPLE_W    = 6;
endpackage

// File: rtl/ssg_rate_divider.sv
// rtl/ssg_rate_divider.sv - reloadable down-counter ticking at zero, shared by SSG voices
module ssg_rate_divider #(
  parameter int W = 12
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         load_i,
  input  logic [W-1:0] period_i,
  output logic         tick_o
);

  logic [W-1:0] count_q, count_d;

  assign tick_o = en_i && (count_q == '0);

  // Period is only sampled at reload, so a new value waits for the running count to expire.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = period_i;
    end else if (en_i) begin
      count_d = (count_q == '0) ? period_i : count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/lfsr_noise_channel.sv
// rtl/lfsr_noise_channel.sv - LFSR noise voice with rate divider, long/short mode, seed load and volume
module lfsr_noise_channel
  import ssg_pkg::*;
#(
  parameter int          LFSR_W    = 16,
  parameter int          OUT_W     = SSG_SAMPLE_W,
  parameter int          PER_W     = 12,
  parameter logic [15:0] SEED_DEF  = SSG_NOISE_SEED,
  parameter int          LONG_TAP  = 3,
  parameter int          SHORT_TAP = 6
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Enable,
  input  logic              Mode,
  input  logic [PER_W-1:0]  Period,
  input  logic [OUT_W-1:0]  Volume,
  input  logic              SeedLoad,
  input  logic [LFSR_W-1:0] SeedValue,
  output logic [OUT_W-1:0]  Output,
  output logic              Step
);

  localparam logic [LFSR_W-1:0] SEED = LFSR_W'(SEED_DEF);

  generate
    if (LFSR_W < 8) begin : g_bad_width
      $error("lfsr_noise_channel: LFSR_W must be at least 8");
    end
    if (LONG_TAP == 0 || LONG_TAP >= LFSR_W) begin : g_bad_long_tap
      $error("lfsr_noise_channel: LONG_TAP must lie in 1..LFSR_W-1");
    end
    if (SHORT_TAP == 0 || SHORT_TAP >= LFSR_W) begin : g_bad_short_tap
      $error("lfsr_noise_channel: SHORT_TAP must lie in 1..LFSR_W-1");
    end
  endgenerate

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic              step_q, step_d;
  logic              tick;
  logic              fb;

  ssg_rate_divider #(.W(PER_W)) u_div (
    .clk_i    (CLK),
    .rst_ni   (RST),
    .en_i     (Enable),
    .load_i   (SeedLoad),
    .period_i (Period),
    .tick_o   (tick)
  );

  assign fb = lfsr_q[0] ^ ((Mode == SSG_NOISE_SHORT) ? lfsr_q[SHORT_TAP] : lfsr_q[LONG_TAP]);

  // A seed load wins over a coincident shift; a zero seed would lock the register up.
  always_comb begin
    lfsr_d = lfsr_q;
    step_d = 1'b0;
    out_d  = '0;
    if (Enable) begin
      out_d = lfsr_q[0] ? Volume : '0;
    end
    if (SeedLoad) begin
      lfsr_d = (SeedValue == '0) ? SEED : SeedValue;
    end else if (tick) begin
      lfsr_d = {fb, lfsr_q[LFSR_W-1:1]};
      step_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      lfsr_q <= SEED;
      out_q  <= '0;
      step_q <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      out_q  <= out_d;
      step_q <= step_d;
    end
  end

  assign Output = out_q;
  assign Step   = step_q;

endmodule
